// File: rtl/ascon_round_counter_if.sv
// ----------------------------------------------------------------------------
// ascon_round_counter_if
// Control/status bundle of the ASCON round counter.
//   start_i  : load the start index selected by mode_i and enter RUN
//   mode_i   : 00 p_a, 01 p8, 10 p_b, 11 treated as p_a
//   en_i     : advance one round (RUN only)
//   abort_i  : synchronous clear to IDLE
//   cpt_o    : absolute round index
//   const_o  : ASCON round constant for cpt_o
//   busy_o   : high in RUN
//   last_o   : high on the final round
//   done_o   : one-cycle completion pulse
// The slave modport is the counter; the master modport is its controller.
// ----------------------------------------------------------------------------
interface ascon_round_counter_if #(
    parameter int unsigned CPT_W = 4
);
    logic             start_i;
    logic [1:0]       mode_i;
    logic             en_i;
    logic             abort_i;
    logic [CPT_W-1:0] cpt_o;
    logic [7:0]       const_o;
    logic             busy_o;
    logic             last_o;
    logic             done_o;

    modport slave (
        input  start_i,
        input  mode_i,
        input  en_i,
        input  abort_i,
        output cpt_o,
        output const_o,
        output busy_o,
        output last_o,
        output done_o
    );

    modport master (
        output start_i,
        output mode_i,
        output en_i,
        output abort_i,
        input  cpt_o,
        input  const_o,
        input  busy_o,
        input  last_o,
        input  done_o
    );
endinterface

// File: rtl/ascon_round_counter.sv
// ----------------------------------------------------------------------------
// ascon_round_counter
// Round index sequencer for the ASCON permutations p_a, p8 and p_b. The index
// is absolute: every permutation ends on ROUNDS_MAX-1, shorter permutations
// simply start later, so the round constant is a pure function of the index.
// Ports:
//   clock_i  : clock, rising edge
//   resetb_i : asynchronous active-low reset
//   bus      : ascon_round_counter_if.slave (see interface for signal list)
// The interface instance must be built with the same CPT_W as this module.
// ----------------------------------------------------------------------------
module ascon_round_counter #(
    parameter int unsigned CPT_W      = 4,
    parameter int unsigned ROUNDS_MAX = 12,
    parameter int unsigned ROUNDS_B   = 6,
    parameter int unsigned ROUNDS_8   = 8
) (
    input  logic                   clock_i,
    input  logic                   resetb_i,
    ascon_round_counter_if.slave   bus
);

    localparam logic [CPT_W-1:0] START_PA = '0;
    localparam logic [CPT_W-1:0] START_P8 = CPT_W'(ROUNDS_MAX - ROUNDS_8);
    localparam logic [CPT_W-1:0] START_PB = CPT_W'(ROUNDS_MAX - ROUNDS_B);
    localparam logic [CPT_W-1:0] LAST_IDX = CPT_W'(ROUNDS_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CPT_W-1:0] r_cpt;
    logic [CPT_W-1:0] w_cpt_nxt;
    logic [CPT_W-1:0] w_start_idx;
    logic [3:0]       w_idx4;

    // Start index per mode; the reserved encoding falls back to p_a.
    always_comb begin
        w_start_idx = START_PA;
        case (bus.mode_i)
            2'b01:   w_start_idx = START_P8;
            2'b10:   w_start_idx = START_PB;
            default: w_start_idx = START_PA;
        endcase
    end

    // State and index registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= ST_IDLE;
            r_cpt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cpt   <= w_cpt_nxt;
        end
    end

    // Next state and next index; abort beats start beats en.
    always_comb begin
        w_state_nxt = r_state;
        w_cpt_nxt   = r_cpt;
        if (bus.abort_i) begin
            w_state_nxt = ST_IDLE;
            w_cpt_nxt   = '0;
        end else if (bus.start_i) begin
            // Also restarts an active run without a done pulse.
            w_state_nxt = ST_RUN;
            w_cpt_nxt   = w_start_idx;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_RUN: begin
                    if (bus.en_i) begin
                        if (r_cpt == LAST_IDX) begin
                            // Final round consumed: park the index at 0.
                            w_state_nxt = ST_DONE;
                            w_cpt_nxt   = '0;
                        end else begin
                            w_cpt_nxt = r_cpt + CPT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cpt_nxt   = '0;
                end
            endcase
        end
    end

    // Status outputs are decodes of registered state, so reset clears them at once.
    assign w_idx4      = 4'(r_cpt);
    assign bus.cpt_o   = r_cpt;
    assign bus.const_o = {4'hF - w_idx4, w_idx4};
    assign bus.busy_o  = (r_state == ST_RUN);
    assign bus.last_o  = (r_state == ST_RUN) && (r_cpt == LAST_IDX);
    assign bus.done_o  = (r_state == ST_DONE);

endmodule

// File: tb/tb_ascon_round_counter.sv
module tb_ascon_round_counter;

    logic clk;
    logic resetb;
    int   checks;
    int   errors;

    ascon_round_counter_if #(.CPT_W(4)) bus ();

    ascon_round_counter #(
        .CPT_W(4), .ROUNDS_MAX(12), .ROUNDS_B(6), .ROUNDS_8(8)
    ) dut (
        .clock_i  (clk),
        .resetb_i (resetb),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written ASCON round constants for indices 0..11.
    function automatic logic [7:0] exp_const(input int i);
        case (i)
            0:  return 8'hF0;
            1:  return 8'hE1;
            2:  return 8'hD2;
            3:  return 8'hC3;
            4:  return 8'hB4;
            5:  return 8'hA5;
            6:  return 8'h96;
            7:  return 8'h87;
            8:  return 8'h78;
            9:  return 8'h69;
            10: return 8'h5A;
            11: return 8'h4B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0; bus.mode_i = 2'b00; bus.en_i = 1'b0; bus.abort_i = 1'b0;
        resetb = 1'b0;
        #12;
        checks++;
        if (bus.cpt_o !== 4'd0 || bus.const_o !== 8'hF0 || bus.busy_o !== 1'b0 ||
            bus.last_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cpt=%0d const=%h busy=%b last=%b done=%b, want 0 F0 0 0 0",
                     bus.cpt_o, bus.const_o, bus.busy_o, bus.last_o, bus.done_o);
        end
        @(negedge clk);
        resetb = 1'b1;
        bus.en_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.cpt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: cpt=%0d busy=%b done=%b, want 0 0 0",
                         bus.cpt_o, bus.busy_o, bus.done_o);
            end
        end
        bus.en_i = 1'b0;
    endtask

    task automatic test_full_run(input logic [1:0] mode, input int exp_start, input int exp_n);
        int count;
        int idx;
        bus.start_i = 1'b1; bus.mode_i = mode; bus.en_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        count = 0;
        while (bus.done_o !== 1'b1 && count < 20) begin
            idx = exp_start + count;
            checks++;
            if (bus.cpt_o !== 4'(idx) || bus.const_o !== exp_const(idx) ||
                bus.busy_o !== 1'b1 || bus.last_o !== (idx == 11) || bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL run_seq mode=%0d: cpt=%0d const=%h busy=%b last=%b done=%b, want %0d %h 1 %b 0",
                         mode, bus.cpt_o, bus.const_o, bus.busy_o, bus.last_o, bus.done_o,
                         idx, exp_const(idx), (idx == 11));
            end
            step();
            count++;
        end
        checks++;
        if (bus.done_o !== 1'b1 || count !== exp_n || bus.cpt_o !== 4'd0 ||
            bus.busy_o !== 1'b0 || bus.last_o !== 1'b0) begin
            errors++;
            $display("FAIL run_done mode=%0d: done=%b advances=%0d cpt=%0d busy=%b, want 1 %0d 0 0",
                     mode, bus.done_o, count, bus.cpt_o, bus.busy_o, exp_n);
        end
        step();
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cpt_o !== 4'd0) begin
            errors++;
            $display("FAIL done_single_pulse mode=%0d: done=%b busy=%b cpt=%0d, want 0 0 0",
                     mode, bus.done_o, bus.busy_o, bus.cpt_o);
        end
        bus.en_i = 1'b0;
    endtask

    task automatic test_en_toggle();
        int   qual;
        int   exp_cpt;
        logic en_v;
        bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.en_i = 1'b0;
        step();
        bus.start_i = 1'b0;
        qual = 0; exp_cpt = 0; en_v = 1'b1;
        for (int g = 0; g < 60; g++) begin
            bus.en_i = en_v;
            step();
            if (en_v) qual++;
            if (bus.done_o === 1'b1) break;
            if (en_v) exp_cpt++;
            checks++;
            if (bus.cpt_o !== 4'(exp_cpt)) begin
                errors++;
                $display("FAIL en_toggle_hold: cpt=%0d want %0d (en=%b)", bus.cpt_o, exp_cpt, en_v);
            end
            en_v = ~en_v;
        end
        checks++;
        if (bus.done_o !== 1'b1 || qual !== 12) begin
            errors++;
            $display("FAIL en_toggle_done: done=%b qualified_en=%0d, want 1 12", bus.done_o, qual);
        end
        bus.en_i = 1'b0;
        step();
    endtask

    task automatic test_restart();
        int count;
        bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.en_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 7; k++) step();
        checks++;
        if (bus.cpt_o !== 4'd7) begin
            errors++;
            $display("FAIL restart_pre: cpt=%0d want 7", bus.cpt_o);
        end
        bus.start_i = 1'b1; bus.mode_i = 2'b10;
        step();
        bus.start_i = 1'b0;
        checks++;
        if (bus.cpt_o !== 4'd6 || bus.const_o !== 8'h96 || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_pb: cpt=%0d const=%h busy=%b done=%b, want 6 96 1 0",
                     bus.cpt_o, bus.const_o, bus.busy_o, bus.done_o);
        end
        count = 0;
        while (bus.done_o !== 1'b1 && count < 20) begin
            step();
            count++;
        end
        checks++;
        if (bus.done_o !== 1'b1 || count !== 6) begin
            errors++;
            $display("FAIL restart_done: done=%b advances=%0d, want 1 6", bus.done_o, count);
        end
        bus.en_i = 1'b0;
        step();
    endtask

    task automatic test_abort();
        bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.en_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 9; k++) step();
        checks++;
        if (bus.cpt_o !== 4'd9) begin
            errors++;
            $display("FAIL abort_pre: cpt=%0d want 9", bus.cpt_o);
        end
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        checks++;
        if (bus.cpt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: cpt=%0d busy=%b done=%b, want 0 0 0",
                     bus.cpt_o, bus.busy_o, bus.done_o);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.cpt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_stays_idle: cpt=%0d busy=%b done=%b, want 0 0 0",
                         bus.cpt_o, bus.busy_o, bus.done_o);
            end
        end
        bus.en_i = 1'b0;
    endtask

    task automatic test_start_abort_same();
        // From IDLE.
        bus.start_i = 1'b1; bus.abort_i = 1'b1; bus.mode_i = 2'b01; bus.en_i = 1'b1;
        step();
        checks++;
        if (bus.cpt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: cpt=%0d busy=%b done=%b, want 0 0 0",
                     bus.cpt_o, bus.busy_o, bus.done_o);
        end
        // From RUN.
        bus.abort_i = 1'b0; bus.mode_i = 2'b01;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        checks++;
        if (bus.cpt_o !== 4'd6 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_abort_pre: cpt=%0d busy=%b, want 6 1", bus.cpt_o, bus.busy_o);
        end
        bus.start_i = 1'b1; bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.en_i = 1'b0;
        checks++;
        if (bus.cpt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_run: cpt=%0d busy=%b done=%b, want 0 0 0",
                     bus.cpt_o, bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_done_start();
        int dones;
        int count;
        bus.start_i = 1'b1; bus.mode_i = 2'b10; bus.en_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (bus.cpt_o !== 4'd11 || bus.last_o !== 1'b1 || bus.const_o !== 8'h4B) begin
            errors++;
            $display("FAIL done_start_last: cpt=%0d last=%b const=%h, want 11 1 4B",
                     bus.cpt_o, bus.last_o, bus.const_o);
        end
        step();
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL done_start_pulse: done=%b want 1", bus.done_o);
        end
        bus.start_i = 1'b1; bus.mode_i = 2'b01;
        step();
        bus.start_i = 1'b0;
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.cpt_o !== 4'd4 || bus.const_o !== 8'hB4) begin
            errors++;
            $display("FAIL done_start_rerun: done=%b busy=%b cpt=%0d const=%h, want 0 1 4 B4",
                     bus.done_o, bus.busy_o, bus.cpt_o, bus.const_o);
        end
        dones = 0; count = 0;
        while (bus.done_o !== 1'b1 && count < 20) begin
            step();
            count++;
        end
        for (int k = 0; k < 3; k++) begin
            if (bus.done_o === 1'b1) dones++;
            step();
        end
        checks++;
        if (count !== 8 || dones !== 1) begin
            errors++;
            $display("FAIL done_start_p8: advances=%0d done_pulses=%0d, want 8 1", count, dones);
        end
        bus.en_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.en_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 5; k++) step();
        #2;
        resetb = 1'b0;
        #1;
        checks++;
        if (bus.cpt_o !== 4'd0 || bus.const_o !== 8'hF0 || bus.busy_o !== 1'b0 ||
            bus.last_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cpt=%0d const=%h busy=%b last=%b done=%b, want 0 F0 0 0 0",
                     bus.cpt_o, bus.const_o, bus.busy_o, bus.last_o, bus.done_o);
        end
        @(posedge clk);
        #3;
        resetb = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            checks++;
            if (bus.cpt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: cpt=%0d busy=%b done=%b, want 0 0 0",
                         bus.cpt_o, bus.busy_o, bus.done_o);
            end
        end
        bus.en_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetb = 1'b1;
        test_reset();
        test_full_run(2'b00, 0, 12);
        test_full_run(2'b01, 4, 8);
        test_full_run(2'b10, 6, 6);
        test_full_run(2'b11, 0, 12);
        test_en_toggle();
        test_restart();
        test_abort();
        test_start_abort_same();
        test_done_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
